spi_router: RTL and testbench

Parametrised successor to the fixed SPI slave mux on icedaq. It routes one primary SPI slave port to one of `NCH` downstream SPI devices. The selection is written over a separate oversampled control SPI port and read back from the same port. A selection change never takes effect while a primary transaction is in progress; it is deferred until the primary port is idle. The block sits between the host SPI pins and the ADC/DAC/ID-ROM slaves.

---
 rtl/spi_router_pkg.sv | 10 +
 rtl/spi_router_if.sv | 9 +
 rtl/spi_byte_slave.sv | 72 +++++++
 rtl/spi_router.sv | 88 ++++++++
 tb/tb_spi_router.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_router_pkg.sv
// spi_router_pkg: command codes, status marker, receiver states and selection-width helper
package spi_router_pkg;
  localparam logic [7:0] CMD_SEL_BASE = 8'h10;
  localparam logic [7:0] CMD_NONE = 8'h0F;
  localparam logic [1:0] STAT_MARK = 2'b10;
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_DONE} rx_state_e;
  function automatic int sel_width(input int nch);
    return nch > 1 ? $clog2(nch) : 1;
  endfunction
endpackage

// File: rtl/spi_router_if.sv
// spi_router_if: W-lane SPI bundle; master drives ss/sclk/mosi, slave drives miso
interface spi_router_if #(parameter int W = 1);
  logic [W-1:0] ss;
  logic [W-1:0] sclk;
  logic [W-1:0] mosi;
  logic [W-1:0] miso;
  modport master(output ss, sclk, mosi, input miso);
  modport slave(input ss, sclk, mosi, output miso);
endinterface

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: oversampled SPI mode-0 byte slave, MSB first
// ports: clk/reset_n; ss/sclk/mosi raw pins in, miso out; tx_byte loaded on ss fall and after each byte;
//        rx_byte with one-cycle rx_valid per completed byte
module spi_byte_slave
  import spi_router_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);
  logic [2:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] s3_q, s3_d;
  rx_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall, shifting;
  assign ss_fall = !s2_q[2] && s3_q[1];
  assign ss_rise = s2_q[2] && !s3_q[1];
  assign sclk_rise = s2_q[1] && !s3_q[0];
  assign sclk_fall = !s2_q[1] && s3_q[0];
  assign shifting = state_q == RX_SHIFT;
  assign miso = state_q != RX_IDLE && tx_q[7];
  assign rx_byte = rx_q;
  assign rx_valid = state_q == RX_DONE;
  always_comb begin
    s1_d = {ss, sclk, mosi};
    s2_d = s1_q;
    s3_d = s2_q[2:1];
    state_d = state_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    if (ss_rise) begin
      state_d = RX_IDLE;
    end else if (ss_fall || state_q == RX_DONE) begin
      state_d = RX_SHIFT;
      cnt_d = '0;
      tx_d = tx_byte;
    end else if (shifting && sclk_rise) begin
      rx_d = {rx_q[6:0], s2_q[0]};
      cnt_d = cnt_q + 3'd1;
      state_d = cnt_q == 3'd7 ? RX_DONE : RX_SHIFT;
    end else if (shifting && sclk_fall && cnt_q != 3'd0) begin
      // the fall after the last bit of a byte (cnt 0) must not disturb the reloaded status
      tx_d = {tx_q[6:0], 1'b0};
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_q <= 3'b100;
      s2_q <= 3'b100;
      s3_q <= 2'b10;
      state_q <= RX_IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
    end
endmodule

// File: rtl/spi_router.sv
// spi_router: routes the primary SPI port to one of NCH devices, selection set over a control SPI port
// ports: clk/reset_n; ctl control SPI (slave); s primary SPI (slave); m downstream SPI (master, NCH lanes);
//        sel active index, connected, pending deferred request
module spi_router
  import spi_router_pkg::*;
#(
  parameter int NCH = 4,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  spi_router_if.slave     ctl,
  spi_router_if.slave     s,
  spi_router_if.master    m,
  output logic [SELW-1:0] sel,
  output logic            connected,
  output logic            pending
);
  logic [7:0] rx_byte;
  logic rx_valid, cmd_sel, cmd_ok, s_idle;
  logic [1:0] ssy_q, ssy_d;
  logic [SELW-1:0] sel_q, sel_d, req_sel_q, req_sel_d, new_sel;
  logic conn_q, conn_d, req_conn_q, req_conn_d, pend_q, pend_d;
  logic [NCH-1:0] hit;
  spi_byte_slave u_ctl (
    .clk(clk),
    .reset_n(reset_n),
    .ss(ctl.ss[0]),
    .sclk(ctl.sclk[0]),
    .mosi(ctl.mosi[0]),
    .miso(ctl.miso[0]),
    .tx_byte({STAT_MARK, pend_q, conn_q, 4'(sel_q)}),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid)
  );
  assign s_idle = ssy_q[1];
  assign new_sel = SELW'(rx_byte[3:0]);
  assign cmd_sel = (rx_byte & 8'hF0) == CMD_SEL_BASE && 5'(rx_byte[3:0]) < 5'(NCH);
  assign cmd_ok = rx_valid && (cmd_sel || rx_byte == CMD_NONE);
  always_comb begin
    ssy_d = {ssy_q[0], s.ss[0]};
    sel_d = sel_q;
    conn_d = conn_q;
    req_sel_d = req_sel_q;
    req_conn_d = req_conn_q;
    pend_d = pend_q;
    // selection only moves while the synchronised primary select is idle, keeping m_* glitch-free
    if (cmd_ok && s_idle) begin
      sel_d = cmd_sel ? new_sel : sel_q;
      conn_d = cmd_sel;
      pend_d = 1'b0;
    end else if (cmd_ok) begin
      req_sel_d = new_sel;
      req_conn_d = cmd_sel;
      pend_d = 1'b1;
    end else if (pend_q && s_idle) begin
      sel_d = req_conn_q ? req_sel_q : sel_q;
      conn_d = req_conn_q;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ssy_q <= 2'b11;
      sel_q <= '0;
      conn_q <= 1'b0;
      req_sel_q <= '0;
      req_conn_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ssy_q <= ssy_d;
      sel_q <= sel_d;
      conn_q <= conn_d;
      req_sel_q <= req_sel_d;
      req_conn_q <= req_conn_d;
      pend_q <= pend_d;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit[i] = conn_q && sel_q == SELW'(i);
    assign m.ss[i] = hit[i] ? s.ss[0] : 1'b1;
    assign m.sclk[i] = hit[i] && s.sclk[0];
    assign m.mosi[i] = hit[i] && s.mosi[0];
  end
  assign s.miso[0] = !s.ss[0] && |(hit & m.miso);
  assign sel = sel_q;
  assign connected = conn_q;
  assign pending = pend_q;
endmodule

// File: tb/tb_spi_router.sv
// tb_spi_router: directed plus randomized self-checking bench for spi_router against a behavioural model
module tb_spi_router;
  localparam int NCH = 4;
  localparam int SELW = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [SELW-1:0] sel;
  logic connected, pending;
  int checks = 0, passed = 0, fails = 0;
  int msel = 0;
  bit mconn = 1'b0, mpend = 1'b0;
  logic [7:0] mreq = 8'h00;
  logic [7:0] rx, b;
  int r;
  spi_router_if #(.W(1)) ctl_if ();
  spi_router_if #(.W(1)) s_if ();
  spi_router_if #(.W(NCH)) m_if ();
  spi_router #(.NCH(NCH), .SELW(SELW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ctl(ctl_if),
    .s(s_if),
    .m(m_if),
    .sel(sel),
    .connected(connected),
    .pending(pending)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] status();
    return {2'b10, mpend, mconn, 4'(msel)};
  endfunction
  function automatic bit is_cmd(input logic [7:0] v);
    return v == 8'h0F || (int'(v) >= 16 && int'(v) < 16 + NCH);
  endfunction
  task automatic model_apply(input logic [7:0] v);
    mconn = v != 8'h0F;
    if (mconn) msel = int'(v) - 16;
  endtask
  task automatic model_cmd(input logic [7:0] v);
    if (is_cmd(v)) begin
      if (s_if.ss[0]) begin
        model_apply(v);
        mpend = 1'b0;
      end else begin
        mreq = v;
        mpend = 1'b1;
      end
    end
  endtask
  task automatic model_release();
    if (mpend) model_apply(mreq);
    mpend = 1'b0;
  endtask
  task automatic chk_state(input string tag);
    chk(tag, 32'({pending, connected, connected ? sel : 4'd0}), 32'({mpend, mconn, mconn ? 4'(msel) : 4'd0}));
  endtask
  task automatic chk_path(input string tag);
    logic [NCH-1:0] es, ec, em;
    logic eo;
    #1;
    for (int i = 0; i < NCH; i++) begin
      es[i] = (mconn && msel == i) ? s_if.ss[0] : 1'b1;
      ec[i] = mconn && msel == i && s_if.sclk[0];
      em[i] = mconn && msel == i && s_if.mosi[0];
    end
    eo = mconn && !s_if.ss[0] && m_if.miso[msel];
    chk(tag, 32'({m_if.ss, m_if.sclk, m_if.mosi, s_if.miso}), 32'({es, ec, em, eo}));
  endtask
  task automatic prim(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_if.sclk = ~s_if.sclk;
      s_if.mosi = 1'($urandom);
      m_if.miso = NCH'($urandom);
      chk_path("path");
    end
  endtask
  task automatic ctl_bits(input logic [7:0] tx, input int n, output logic [7:0] q);
    q = '0;
    @(negedge clk);
    ctl_if.ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 7; i > 7 - n; i--) begin
      ctl_if.mosi = tx[i];
      repeat (4) @(negedge clk);
      q[i] = ctl_if.miso[0];
      ctl_if.sclk = 1'b1;
      if (i > 8 - n) begin
        repeat (4) @(negedge clk);
        ctl_if.sclk = 1'b0;
      end
    end
  endtask
  task automatic ctl_end();
    repeat (4) @(negedge clk);
    ctl_if.sclk = 1'b0;
    repeat (4) @(negedge clk);
    ctl_if.ss = 1'b1;
    ctl_if.mosi = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic ctl_cmd(input logic [7:0] tx, output logic [7:0] q);
    logic [7:0] e, k;
    e = status();
    k = mconn ? 8'hFF : 8'hF0;
    ctl_bits(tx, 8, q);
    ctl_end();
    model_cmd(tx);
    chk("status", 32'(q & k), 32'(e & k));
  endtask
  initial begin
    ctl_if.ss = 1'b1;
    ctl_if.sclk = 1'b0;
    ctl_if.mosi = 1'b0;
    s_if.ss = 1'b0;
    s_if.sclk = 1'b1;
    s_if.mosi = 1'b1;
    m_if.miso = '1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'({sel, connected, pending, ctl_if.miso}), 32'd0);
    chk_path("rst_path");
    s_if.ss = 1'b1;
    s_if.sclk = 1'b0;
    s_if.mosi = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    s_if.ss = 1'b0;
    prim(16);
    s_if.ss = 1'b1;
    chk_path("idle_path");
    ctl_cmd(8'h00, rx);
    chk("rd_80", 32'(rx), 32'h80);
    ctl_bits(8'h12, 8, rx);
    chk("st_pre12", 32'(rx), 32'h80);
    repeat (3) @(negedge clk);
    chk("lat3", 32'({connected, sel}), 32'({1'b0, 4'd0}));
    @(negedge clk);
    chk("lat4", 32'({connected, sel}), 32'({1'b1, 4'd2}));
    ctl_end();
    model_cmd(8'h12);
    s_if.ss = 1'b0;
    prim(16);
    s_if.ss = 1'b1;
    ctl_cmd(8'h00, rx);
    chk("rd_92", 32'(rx), 32'h92);
    s_if.ss = 1'b0;
    prim(4);
    ctl_cmd(8'h11, rx);
    chk_state("pend_set");
    chk("pend_flag", 32'({pending, sel}), 32'({1'b1, 4'd2}));
    ctl_cmd(8'h00, rx);
    chk("rd_b2", 32'(rx), 32'hB2);
    prim(4);
    @(negedge clk);
    s_if.ss = 1'b1;
    repeat (2) @(negedge clk);
    chk("defer2", 32'({pending, sel}), 32'({1'b1, 4'd2}));
    @(negedge clk);
    chk("defer3", 32'({pending, sel}), 32'({1'b0, 4'd1}));
    model_release();
    s_if.ss = 1'b0;
    prim(2);
    ctl_cmd(8'h13, rx);
    ctl_cmd(8'h55, rx);
    chk_state("pend13");
    @(negedge clk);
    s_if.ss = 1'b1;
    repeat (3) @(negedge clk);
    model_release();
    chk("sel3", 32'({pending, connected, sel}), 32'({1'b0, 1'b1, 4'd3}));
    ctl_cmd(8'h14, rx);
    chk("sel3_keep", 32'({connected, sel}), 32'({1'b1, 4'd3}));
    ctl_bits(8'h0F, 5, rx);
    ctl_end();
    chk("partial", 32'({connected, pending, sel}), 32'({1'b1, 1'b0, 4'd3}));
    ctl_cmd(8'h0F, rx);
    chk("disc", 32'({connected, pending}), 32'd0);
    s_if.ss = 1'b0;
    prim(4);
    s_if.ss = 1'b1;
    ctl_cmd(8'h11, rx);
    s_if.ss = 1'b0;
    prim(3);
    ctl_bits(8'h13, 4, rx);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_state", 32'({sel, connected, pending, ctl_if.miso}), 32'd0);
    mconn = 1'b0;
    msel = 0;
    mpend = 1'b0;
    chk_path("arst_path");
    ctl_if.ss = 1'b1;
    ctl_if.sclk = 1'b0;
    ctl_if.mosi = 1'b0;
    s_if.ss = 1'b1;
    s_if.sclk = 1'b0;
    s_if.mosi = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_state("post_rst");
    ctl_cmd(8'h00, rx);
    chk("rd_80b", 32'(rx), 32'h80);
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      b = r < 5 ? 8'(16 + $urandom_range(0, NCH + 1)) : r < 7 ? 8'h0F : 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        s_if.ss = 1'b0;
        prim(2);
      end
      ctl_cmd(b, rx);
      chk_state("rnd_cmd");
      if (!s_if.ss[0]) begin
        prim(2);
        if ($urandom_range(0, 2) != 0) begin
          @(negedge clk);
          s_if.ss = 1'b1;
          repeat (3) @(negedge clk);
          model_release();
        end
      end
      chk_state("rnd_state");
      chk_path("rnd_path");
    end
    @(negedge clk);
    s_if.ss = 1'b1;
    repeat (4) @(negedge clk);
    model_release();
    chk_state("final");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
